// File: rtl/mux3ne1_reg.sv
// mux3ne1_reg: registered 3-to-1 word mux with illegal-select error flag
module mux3ne1_reg #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Hyrja0,
  input  logic [WIDTH-1:0] Hyrja1,
  input  logic [WIDTH-1:0] Hyrja2,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] Dalja,
  output logic             Gabim
);
  logic [WIDTH-1:0] sel;
  logic             err;
  always_comb begin
    sel = S == 3'd0 ? Hyrja0 :
          S == 3'd1 ? Hyrja1 :
          S == 3'd2 ? Hyrja2 : '0;
    err = S > 3'd2;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Dalja <= '0;
      Gabim <= 1'b0;
    end else begin
      Dalja <= sel;
      Gabim <= err;
    end
  end
endmodule

// File: tb/tb_mux3ne1_reg.sv
// tb_mux3ne1_reg: directed plan plus random stimulus checked against a behavioural model
module tb_mux3ne1_reg;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Hyrja0 = '0, Hyrja1 = '0, Hyrja2 = '0;
  logic [2:0]  S = '0;
  logic [15:0] Dalja;
  logic        Gabim;
  int checks = 0;
  int failures = 0;

  mux3ne1_reg #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .Hyrja0(Hyrja0), .Hyrja1(Hyrja1),
    .Hyrja2(Hyrja2), .S(S), .Dalja(Dalja), .Gabim(Gabim)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic rst, input logic [2:0] s,
                                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [15:0] bus [3];
    bus[0] = a; bus[1] = b; bus[2] = c;
    if (rst) return 17'd0;
    if (int'(s) < 3) return {1'b0, bus[s]};
    return {1'b1, 16'd0};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [2:0] s,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [16:0] e;
    Reset = rst; S = s; Hyrja0 = a; Hyrja1 = b; Hyrja2 = c;
    e = model(rst, s, a, b, c);
    @(posedge Clock); #1;
    check({tag, ".dalja"}, 32'(Dalja), 32'(e[15:0]));
    check({tag, ".gabim"}, 32'(Gabim), 32'(e[16]));
  endtask

  initial begin
    step("reset0", 1'b1, 3'd0, 16'd5, 16'd20, 16'd23);
    step("reset1", 1'b1, 3'd0, 16'd5, 16'd20, 16'd23);
    step("release", 1'b0, 3'd0, 16'd5, 16'd20, 16'd23);
    for (int i = 0; i < 3; i++) step("legal", 1'b0, 3'(i), 16'd5, 16'd20, 16'd23);
    for (int i = 3; i < 8; i++) step("illegal", 1'b0, 3'(i), 16'd5, 16'd20, 16'd23);
    step("recover", 1'b0, 3'd1, 16'd5, 16'd20, 16'd23);
    step("hold_pre", 1'b0, 3'd2, 16'd5, 16'd20, 16'd23);
    Hyrja2 = 16'hFFFF; #2;
    check("hold_between", 32'(Dalja), 32'd23);
    step("hold_post", 1'b0, 3'd2, 16'd5, 16'd20, 16'hFFFF);
    step("mid_pre", 1'b0, 3'd1, 16'd5, 16'd20, 16'd23);
    step("mid_rst", 1'b1, 3'd1, 16'd5, 16'd20, 16'd23);
    step("mid_post", 1'b0, 3'd1, 16'd5, 16'd20, 16'd23);
    step("width", 1'b0, 3'd0, 16'h8001, 16'd20, 16'd23);
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
           16'($urandom), 16'($urandom), 16'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux3ne1_reg.md
Name: mux3ne1_reg

Overview:
- Registered 3-to-1 word multiplexer for the 16-bit single-cycle datapath; selects between three operand/result buses, e.g. ALU result, memory data and immediate/PC value.
- Select is a 3-bit binary code. Codes 3..7 are illegal; they produce zero and raise an error flag.
- The output is captured on the rising clock edge (one-cycle latency) and cleared by a synchronous reset.

Parameters:
- WIDTH, 16, bit width of each data input and of the output.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Hyrja0  input  WIDTH  data input 0, selected when S = 3'd0.
- Hyrja1  input  WIDTH  data input 1, selected when S = 3'd1.
- Hyrja2  input  WIDTH  data input 2, selected when S = 3'd2.
- S  input  3  binary select code.
- Dalja  output  WIDTH  registered selected data.
- Gabim  output  1  registered illegal-select flag; high when the captured S was 3..7.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; no asynchronous paths.
- Reset:
  - On a rising edge with Reset=1: Dalja <= 0 and Gabim <= 0, regardless of S or data.
  - Reset has priority over everything else.
  - Reset asserted mid-stream clears both outputs at that edge. The first edge after Reset deasserts captures normally.
- Normal operation, on each rising edge with Reset=0:
  - S=0: Dalja <= Hyrja0, Gabim <= 0.
  - S=1: Dalja <= Hyrja1, Gabim <= 0.
  - S=2: Dalja <= Hyrja2, Gabim <= 0.
  - S=3..7: Dalja <= 0, Gabim <= 1.
- Latency:
  - Exactly one cycle from inputs/S to Dalja/Gabim.
  - There is no enable, so the outputs update every cycle.
  - Between edges the outputs hold their value and do not glitch.
- Width rules:
  - Data passes bit-exact, with no sign extension or arithmetic.
  - All of S[2:0] is decoded, so S[2]=1 is always illegal.
- Select logic is a full case with a default, so no latches are inferred.
- Simultaneous input changes are allowed: only values present at the sampling edge matter.
- Power-up before the first Reset is undefined. Verification must apply Reset before checking.

Test Plan:
- Reset: Hyrja0=5, Hyrja1=20, Hyrja2=23, S=0, Reset=1 for 2 edges -> Dalja=0, Gabim=0. After release, the next edge gives Dalja=5.
- Legal sweep: Hyrja0=5, Hyrja1=20, Hyrja2=23, S=0,1,2 on successive edges -> Dalja=5, 20, 23, one edge after each S change, with Gabim=0.
- Illegal codes: same data, S=3,4,5,6,7 each for one edge -> Dalja=0 and Gabim=1 after each edge. Then S=1 -> Dalja=20, Gabim=0 on the next edge.
- Latency/hold: S=2, Hyrja2 changes 23->16'hFFFF between edges -> Dalja stays 23 until the next rising edge, then becomes 16'hFFFF.
- Reset mid-stream: S=1, Hyrja1=20, steady; assert Reset for one edge -> Dalja=0. Deassert -> Dalja=20 one edge later.
- Full width: Hyrja0=16'h8001, S=0 -> Dalja=16'h8001 exactly, with no bit loss or sign effects.
